// File: rtl/mux4_rr_arbiter.sv
// 4:1 round-robin arbiter/mux with burst limit; 1-cycle arbitration, 1-cycle registered data path.
// A stalled output register (out_valid & !out_ready) withdraws in_ready and freezes the burst count.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_valid,
    output logic [3:0] in_ready,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] out_sel,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] BURST = 4'(MAX_BURST);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_g;
    logic [1:0] w_g_nxt;
    logic [1:0] r_last;
    logic [1:0] w_last_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_out_vld;
    logic       w_out_vld_nxt;
    logic [7:0] r_out_dat;
    logic [7:0] w_out_dat_nxt;
    logic [1:0] r_out_sel;
    logic [1:0] w_out_sel_nxt;

    logic [1:0] w_pick;
    logic [7:0] w_sel_dat;
    logic       w_ready;
    logic       w_xfer;

    // Scan from the far end of the rotation so the nearest requester after r_last wins.
    always_comb begin
        w_pick = r_last + 2'd1;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[r_last + 2'(k + 1)]) begin
                w_pick = r_last + 2'(k + 1);
            end
        end
    end

    always_comb begin
        case (r_g)
            2'd0:    w_sel_dat = in0;
            2'd1:    w_sel_dat = in1;
            2'd2:    w_sel_dat = in2;
            default: w_sel_dat = in3;
        endcase
    end

    assign w_ready  = (r_state == GRANT) && (!r_out_vld || out_ready);
    assign w_xfer   = w_ready && in_valid[r_g];
    assign in_ready = w_ready ? (4'b0001 << r_g) : 4'b0000;

    always_comb begin
        w_state_nxt   = r_state;
        w_g_nxt       = r_g;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_out_vld_nxt = r_out_vld && !out_ready;
        w_out_dat_nxt = r_out_dat;
        w_out_sel_nxt = r_out_sel;

        case (r_state)
            IDLE: begin
                if (|in_valid) begin
                    w_state_nxt = GRANT;
                    w_g_nxt     = w_pick;
                    w_cnt_nxt   = 4'd0;
                end
            end
            GRANT: begin
                if (!in_valid[r_g]) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_g;
                end else if (w_xfer) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt + 4'd1 == BURST) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = r_g;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_xfer) begin
            w_out_vld_nxt = 1'b1;
            w_out_dat_nxt = w_sel_dat;
            w_out_sel_nxt = r_g;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_g       <= 2'd0;
            r_last    <= 2'd3;
            r_cnt     <= 4'd0;
            r_out_vld <= 1'b0;
            r_out_dat <= 8'h00;
            r_out_sel <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_g       <= w_g_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_out_vld <= w_out_vld_nxt;
            r_out_dat <= w_out_dat_nxt;
            r_out_sel <= w_out_sel_nxt;
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign out_sel   = r_out_sel;
    assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus a random run against a transaction-level scoreboard.
module tb_mux4_rr_arbiter;

    localparam int MB    = 4;
    localparam int BOUND = 3 * (MB + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [7:0] din [4];
    logic [7:0] in0, in1, in2, in3;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_sel;
    logic       busy;

    assign in0 = din[0];
    assign in1 = din[1];
    assign in2 = din[2];
    assign in3 = din[3];

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_BURST(MB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sel  (out_sel),
        .busy     (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard state for the random run
    logic [9:0] sb_q [$];
    int         wait_cnt [4];
    logic [3:0] acc;
    logic [7:0] prev_dat;
    logic [1:0] prev_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ovld"}, 32'(out_valid), 0);
        chk({tag, "_odat"}, 32'(out_data), 0);
        chk({tag, "_osel"}, 32'(out_sel), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rdy"},  32'(in_ready), 0);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
    endtask

    // Consume the output word (if any) against the global acceptance order.
    task automatic sample_out();
        logic [9:0] w;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("rnd_spurious_word", 32'({out_sel, out_data}), 32'h3ff);
            end else begin
                w = sb_q.pop_front();
                chk("rnd_word", 32'({out_sel, out_data}), 32'(w));
            end
        end
        if (!out_valid) begin
            chk("rnd_hold_dat", 32'(out_data), 32'(prev_dat));
            chk("rnd_hold_sel", 32'(out_sel), 32'(prev_sel));
        end
        prev_dat = out_data;
        prev_sel = out_sel;
    endtask

    initial begin
        int         ch;
        logic [7:0] word;
        logic [3:0] exp_rdy;

        // ---- first transfer latency ----
        reset_dut();
        in_valid = 4'b0001;
        din[0]   = 8'hA5;
        #1;
        chk("t1_idle_rdy", 32'(in_ready), 0);
        tick();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_rdy", 32'(in_ready), 32'b0001);
        tick();
        chk("t1_ovld", 32'(out_valid), 1);
        chk("t1_odat", 32'(out_data), 32'hA5);
        chk("t1_osel", 32'(out_sel), 0);
        in_valid = 4'b0000;
        tick();
        chk("t1_drain_ovld", 32'(out_valid), 0);
        chk("t1_drain_busy", 32'(busy), 0);
        chk("t1_hold_dat", 32'(out_data), 32'hA5);

        // ---- all channels requesting: bursts of MB with one arbitration cycle between ----
        reset_dut();
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) din[i] = 8'(i * 64);
        for (int k = 0; k < 5 * 5; k++) begin
            #1;
            exp_rdy = (k % 5 == 0) ? 4'b0000 : 4'(1 << ((k / 5) % 4));
            chk("t2_rdy", 32'(in_ready), 32'(exp_rdy));
            ch   = (k / 5) % 4;
            word = din[ch];
            tick();
            if (k % 5 != 0) begin
                chk("t2_odat", 32'(out_data), 32'(word));
                chk("t2_osel", 32'(out_sel), 32'(ch));
                din[ch] = din[ch] + 8'd1;
            end
        end
        in_valid = 4'b0000;
        tick();

        // ---- back-pressure during a channel 2 burst ----
        reset_dut();
        in_valid = 4'b0100;
        din[2]   = 8'h20;
        tick();
        chk("t3_busy", 32'(busy), 1);
        chk("t3_rdy", 32'(in_ready), 32'b0100);
        tick();
        chk("t3_w0", 32'(out_data), 32'h20);
        din[2]    = 8'h21;
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_rdy", 32'(in_ready), 0);
            chk("t3_stall_ovld", 32'(out_valid), 1);
            chk("t3_stall_odat", 32'(out_data), 32'h20);
            chk("t3_stall_busy", 32'(busy), 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_resume_rdy", 32'(in_ready), 32'b0100);
        for (int i = 1; i < MB; i++) begin
            tick();
            chk("t3_word", 32'(out_data), 32'(8'h20 + 8'(i)));
            chk("t3_word_vld", 32'(out_valid), 1);
            din[2] = 8'h20 + 8'(i + 1);
        end
        chk("t3_end_busy", 32'(busy), 0);
        chk("t3_end_rdy", 32'(in_ready), 0);
        in_valid = 4'b0000;
        tick();

        // ---- channel 1 drops early; next grant rotates past it ----
        reset_dut();
        in_valid = 4'b0010;
        din[1]   = 8'h10;
        tick();
        chk("t4_rdy", 32'(in_ready), 32'b0010);
        tick();
        din[1] = 8'h11;
        tick();
        chk("t4_w1", 32'(out_data), 32'h11);
        in_valid = 4'b0101;
        din[0]   = 8'h0A;
        din[2]   = 8'h2A;
        #1;
        chk("t4_drop_rdy", 32'(in_ready), 32'b0010);
        tick();
        chk("t4_exit_busy", 32'(busy), 0);
        chk("t4_exit_rdy", 32'(in_ready), 0);
        tick();
        chk("t4_regrant_busy", 32'(busy), 1);
        chk("t4_regrant_rdy", 32'(in_ready), 32'b0100);
        tick();
        chk("t4_osel", 32'(out_sel), 2);
        chk("t4_odat", 32'(out_data), 32'h2A);
        in_valid = 4'b0000;
        tick();

        // ---- reset mid-burst ----
        reset_dut();
        in_valid = 4'b0011;
        din[0]   = 8'hA0;
        din[1]   = 8'hB0;
        repeat (7) tick();
        chk("t5_pre_ovld", 32'(out_valid), 1);
        chk("t5_pre_osel", 32'(out_sel), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_async");
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_post_busy", 32'(busy), 1);
        chk("t5_post_rdy", 32'(in_ready), 32'b0001);
        in_valid = 4'b0000;
        tick();
        tick();

        // ---- random valid/ready against the scoreboard ----
        reset_dut();
        acc      = 4'b0000;
        prev_dat = out_data;
        prev_sel = out_sel;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    in_valid[i] = ($urandom_range(0, 9) < 7);
                    din[i]      = 8'($urandom);
                    wait_cnt[i] = 0;
                end else if (!in_valid[i] && $urandom_range(0, 3) == 0) begin
                    in_valid[i] = 1'b1;
                    din[i]      = 8'($urandom);
                    wait_cnt[i] = 0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_onehot", 32'($countones(in_ready) <= 1), 1);
            sample_out();
            acc = in_valid & in_ready;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) sb_q.push_back({2'(i), din[i]});
            end
            if (acc != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (in_valid[i] && !acc[i]) begin
                        wait_cnt[i]++;
                        chk("rnd_starve", 32'(wait_cnt[i] <= BOUND), 1);
                    end
                end
            end
            tick();
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            sample_out();
            tick();
        end
        chk("rnd_drain_empty", 32'(sb_q.size()), 0);
        chk("rnd_drain_ovld", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
